// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == TERM)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from a synchronous FIFO (data valid the
// cycle after the read strobe).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);

  if (DATA_W != fifo_uart_pkg::DATA_W || DATA_W + 2 != FRAME_BITS) begin : g_bad_width
    $error("fifo_uart_tx supports only 8-bit data");
  end

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_idx_q;
  logic              tx_q;
  logic              tx_done_q;

  logic [CNT_W-1:0]  baud_cnt;
  logic              baud_tick;
  logic              baud_clr;

  // Read strobe is combinational so it can never fire on a stale empty flag.
  assign fifo_rd_en = !rst && (state_q == IDLE) && tx_enable && !fifo_empty;
  assign baud_clr   = (state_q == IDLE) || (state_q == FETCH);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (baud_clr),
    .cnt_o  (baud_cnt),
    .tick_o (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      // Registered pulse lands in the final cycle of the stop bit.
      tx_done_q <= (state_q == STOP) && (baud_cnt == DONE_CNT);
      unique case (state_q)
        IDLE: if (fifo_rd_en) state_q <= FETCH;
        FETCH: begin
          shift_q <= fifo_data;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (baud_tick) begin
          tx_q    <= shift_q[0];
          state_q <= DATA;
        end
        DATA: if (baud_tick) begin
          shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tx_q <= shift_q[1];
          end
        end
        STOP: if (baud_tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = tx_done_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning byte width; only 8 is supported.
REQ-003 The block SHALL have a port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have a port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have a port tx_enable  input  1  permits fetching a new byte when high.
REQ-006 The block SHALL have a port fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 The block SHALL have a port fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 The block SHALL have a port fifo_rd_en  output  1  one-cycle read strobe to the FIFO.
REQ-009 The block SHALL have a port tx  output  1  registered serial line, 8N1, idle high.
REQ-010 The block SHALL have a port busy  output  1  high whenever the state is not IDLE.
REQ-011 The block SHALL have a port tx_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-012 The state machine SHALL have the states IDLE, FETCH, START, DATA and STOP.
REQ-013 In IDLE with tx_enable=1 and fifo_empty=0, the block SHALL assert fifo_rd_en for exactly that cycle (T) and move to FETCH.
REQ-014 fifo_rd_en SHALL never be asserted outside IDLE, nor while fifo_empty=1 or tx_enable=0.
REQ-015 FETCH SHALL last one cycle (T+1), capture fifo_data into the shift register at its closing edge, clear the baud counter and move to START.
REQ-016 tx SHALL be 0 from cycle T+2 for CLKS_PER_BIT cycles (START).
REQ-017 DATA SHALL drive the 8 bits LSB first, each held CLKS_PER_BIT cycles, tracked by a 3-bit bit index that wraps 7->0 on exit.
REQ-018 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, pulse tx_done in its last cycle, then return to IDLE.
REQ-019 A complete frame SHALL be 10*CLKS_PER_BIT cycles of tx; the earliest next fifo_rd_en SHALL be the first IDLE cycle after STOP, giving an inter-frame idle-high gap of exactly 2 cycles.
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and advance bit or state on terminal count only.
REQ-021 tx_enable deasserted mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-022 fifo_data SHALL be ignored in every cycle except FETCH.
REQ-023 Changes on fifo_empty during FETCH..STOP SHALL have no effect.

Reset
REQ-024 While rst=1, the block SHALL hold tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL drive tx high at the next edge; the in-flight byte is discarded and no fifo_rd_en is issued in the reset cycle.
REQ-026 rst SHALL take priority over every other input.

Structure
REQ-027 Package fifo_uart_pkg SHALL hold the state enumeration, DATA_W=8 and the frame bit count (10).
REQ-028 Baud timing SHALL be a sub-module uart_baud_cnt (count, clear, terminal-count tick); everything else is in fifo_uart_tx.
REQ-029 The block SHALL connect directly to SYN_FIFO: rd_en<-fifo_rd_en, data_out->fifo_data, empty->fifo_empty.

Verification (CLKS_PER_BIT=4)
REQ-030 Single byte: FIFO holds 0xA5 -> one rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); tx_done in cycle 39 of the frame.
REQ-031 Back-to-back: FIFO holds 0x01,0x02,0x03 -> three frames in order with exactly 2 idle-high cycles between them; FIFO ends empty; no rd_en while empty.
REQ-032 Empty FIFO: fifo_empty=1 for 100 cycles -> tx=1, busy=0, fifo_rd_en=0 throughout.
REQ-033 Enable gating: tx_enable dropped in bit 3 of a 0x55 frame -> frame completes; no further rd_en until tx_enable returns to 1.
REQ-034 Mid-frame reset: rst high for 1 cycle during DATA bit 5 -> tx=1 at the next edge, busy=0; the remaining FIFO byte is sent as a complete frame after reset is released.
REQ-035 Loopback check: a bench UART receiver fed 16 random bytes through SYN_FIFO -> received bytes match in order, with no framing errors.
